// File: rtl/fft_radix2.sv
`default_nettype none
// fft_radix2: fully pipelined radix-2 DIT FFT, one N-point complex frame per clock.
// Each stage halves and saturates, so the output is DFT(x)/N; latency LOG2N+1 clocks.
module fft_radix2 #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 4,
  parameter int TW_WIDTH   = 12
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      en,
  input  logic [N*2*DATA_WIDTH-1:0] cplx_data_in,
  output logic [N*2*DATA_WIDTH-1:0] cplx_data_out,
  output logic                      en_out
);

  localparam int     LOG2N  = $clog2(N);
  localparam int     W      = DATA_WIDTH;
  localparam int     PW     = DATA_WIDTH + TW_WIDTH;
  localparam int     SW     = DATA_WIDTH + 2;
  localparam int     FRAC   = 28;
  localparam longint PI_FIX = 64'sd843314857;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  // Twiddles are built from integer Taylor series in Q(FRAC) so the table is
  // fully resolved at elaboration without relying on real-valued math.
  function automatic longint ang_fix(int s, int m);
    return (longint'(2) * PI_FIX * longint'(m)) >>> s;
  endfunction

  function automatic longint cos_fix(longint x);
    longint x2, term, acc;
    x2   = (x * x) >>> FRAC;
    term = longint'(1) <<< FRAC;
    acc  = term;
    for (int k = 1; k <= 12; k++) begin
      term = -(((term * x2) >>> FRAC) / longint'((2 * k - 1) * (2 * k)));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic longint sin_fix(longint x);
    longint x2, term, acc;
    x2   = (x * x) >>> FRAC;
    term = x;
    acc  = x;
    for (int k = 1; k <= 12; k++) begin
      term = -(((term * x2) >>> FRAC) / longint'((2 * k) * (2 * k + 1)));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic logic signed [TW_WIDTH-1:0] to_q(longint v);
    longint mag, r;
    mag = (v < 0) ? -v : v;
    r   = ((mag <<< (TW_WIDTH - 2)) + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    return TW_WIDTH'((v < 0) ? -r : r);
  endfunction

  function automatic int bit_rev(int k);
    int r;
    r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r | (((k >> b) & 1) << (LOG2N - 1 - b));
    end
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat(logic signed [SW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[W-1:0];
    if (v < SAT_MIN) return SAT_MIN[W-1:0];
    return v[W-1:0];
  endfunction

  logic signed [W-1:0] in_re [N];
  logic signed [W-1:0] in_im [N];
  logic signed [W-1:0] st_re [LOG2N+1][N];
  logic signed [W-1:0] st_im [LOG2N+1][N];
  logic signed [W-1:0] nx_re [LOG2N][N];
  logic signed [W-1:0] nx_im [LOG2N][N];
  logic [LOG2N:0]      vld;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    localparam int SRC = bit_rev(k);
    assign in_re[k] = cplx_data_in[(2 * SRC + 1) * W +: W];
    assign in_im[k] = cplx_data_in[2 * SRC * W +: W];
  end

  for (genvar s = 1; s <= LOG2N; s++) begin : g_stage
    for (genvar g = 0; g < N / 2; g++) begin : g_bfly
      localparam int HALF = 1 << (s - 1);
      localparam int M    = g % HALF;
      localparam int I    = (g / HALF) * 2 * HALF + M;
      localparam int J    = I + HALF;
      localparam logic signed [TW_WIDTH-1:0] WR = to_q(cos_fix(ang_fix(s, M)));
      localparam logic signed [TW_WIDTH-1:0] WI = to_q(-sin_fix(ang_fix(s, M)));

      logic signed [PW-1:0] p_re_full, p_im_full;
      logic signed [SW-1:0] p_re, p_im, a_re, a_im;

      assign p_re_full = PW'(st_re[s-1][J]) * PW'(WR) - PW'(st_im[s-1][J]) * PW'(WI);
      assign p_im_full = PW'(st_re[s-1][J]) * PW'(WI) + PW'(st_im[s-1][J]) * PW'(WR);
      // |b*w| < 2^(W+1), so the rescaled product and a +/- p both fit in W+2 bits.
      assign p_re = SW'(p_re_full >>> (TW_WIDTH - 2));
      assign p_im = SW'(p_im_full >>> (TW_WIDTH - 2));
      assign a_re = SW'(st_re[s-1][I]);
      assign a_im = SW'(st_im[s-1][I]);

      assign nx_re[s-1][I] = sat((a_re + p_re) >>> 1);
      assign nx_im[s-1][I] = sat((a_im + p_im) >>> 1);
      assign nx_re[s-1][J] = sat((a_re - p_re) >>> 1);
      assign nx_im[s-1][J] = sat((a_im - p_im) >>> 1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld           <= '0;
      en_out        <= 1'b0;
      cplx_data_out <= '0;
      for (int s = 0; s <= LOG2N; s++) begin
        for (int k = 0; k < N; k++) begin
          st_re[s][k] <= '0;
          st_im[s][k] <= '0;
        end
      end
    end else begin
      vld    <= {vld[LOG2N-1:0], en};
      en_out <= vld[LOG2N];
      if (en) begin
        for (int k = 0; k < N; k++) begin
          st_re[0][k] <= in_re[k];
          st_im[0][k] <= in_im[k];
        end
      end
      for (int s = 1; s <= LOG2N; s++) begin
        if (vld[s-1]) begin
          for (int k = 0; k < N; k++) begin
            st_re[s][k] <= nx_re[s-1][k];
            st_im[s][k] <= nx_im[s-1][k];
          end
        end
      end
      if (vld[LOG2N]) begin
        for (int k = 0; k < N; k++) begin
          cplx_data_out[(2 * k + 1) * W +: W] <= st_re[LOG2N][k];
          cplx_data_out[2 * k * W +: W]       <= st_im[LOG2N][k];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_radix2.sv
`default_nettype none
// tb_fft_radix2: bench for fft_radix2, one W=4 and one W=8 instance sharing clock, reset and en.
module tb_fft_radix2;
  localparam int N   = 16;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         n_rst, en;
  logic [127:0] in4, out4;
  logic [255:0] in8, out8;
  logic         eo4, eo8;

  always #5 clk = ~clk;

  fft_radix2 #(.N(16), .DATA_WIDTH(4), .TW_WIDTH(12)) dut4 (
    .clk(clk), .n_rst(n_rst), .en(en), .cplx_data_in(in4), .cplx_data_out(out4), .en_out(eo4));
  fft_radix2 #(.N(16), .DATA_WIDTH(8), .TW_WIDTH(12)) dut8 (
    .clk(clk), .n_rst(n_rst), .en(en), .cplx_data_in(in8), .cplx_data_out(out8), .en_out(eo8));

  typedef struct packed { int due; logic [127:0] y4; logic [255:0] y8; } pend_t;
  typedef struct packed { int w; logic [255:0] x; logic [255:0] y; } vec_t;

  pend_t        pq[$];
  vec_t         vt[6];
  logic [127:0] x4_exp, hold4;
  logic [255:0] x8_exp, hold8;
  int           cyc, checks, errors;

  function automatic int sext(int v, int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  // component idx: 2k+1 = real of sample k, 2k = imag of sample k
  function automatic int get_c(logic [255:0] f, int idx, int w);
    logic [255:0] t;
    t = f >> (idx * w);
    return sext(int'(t[7:0]) & ((1 << w) - 1), w);
  endfunction

  function automatic logic [255:0] put_c(logic [255:0] f, int idx, int w, int v);
    logic [255:0] m, d;
    m = 256'((1 << w) - 1) << (idx * w);
    d = 256'(v & ((1 << w) - 1)) << (idx * w);
    return (f & ~m) | d;
  endfunction

  function automatic int brev(int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) r = r | (((k >> b) & 1) << (3 - b));
    return r;
  endfunction

  function automatic int rnd(real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int satw(int v, int w);
    int hi;
    hi = (1 << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic logic [255:0] ref_fft(int w, logic [255:0] x);
    int re[N], im[N];
    int half, span, i, j, wr, wi, pr, pim, tr, ti;
    real ang;
    logic [255:0] y;
    for (int k = 0; k < N; k++) begin
      re[k] = get_c(x, 2 * brev(k) + 1, w);
      im[k] = get_c(x, 2 * brev(k), w);
    end
    for (int s = 1; s <= 4; s++) begin
      half = 1 << (s - 1);
      span = 2 * half;
      for (int base = 0; base < N; base += span) begin
        for (int m = 0; m < half; m++) begin
          ang = 2.0 * 3.14159265358979 * m / span;
          wr  = rnd(1024.0 * $cos(ang));
          wi  = rnd(-1024.0 * $sin(ang));
          i   = base + m;
          j   = i + half;
          pr  = (re[j] * wr - im[j] * wi) >>> 10;
          pim = (re[j] * wi + im[j] * wr) >>> 10;
          tr  = re[i];
          ti  = im[i];
          re[i] = satw((tr + pr) >>> 1, w);
          im[i] = satw((ti + pim) >>> 1, w);
          re[j] = satw((tr - pr) >>> 1, w);
          im[j] = satw((ti - pim) >>> 1, w);
        end
      end
    end
    y = '0;
    for (int k = 0; k < N; k++) begin
      y = put_c(y, 2 * k + 1, w, re[k]);
      y = put_c(y, 2 * k, w, im[k]);
    end
    return y;
  endfunction

  function automatic logic [255:0] rand_frame(int w);
    logic [255:0] f;
    int v;
    f = '0;
    for (int c = 0; c < 2 * N; c++) begin
      case ($urandom_range(0, 3))
        0:       v = -(1 << (w - 1));
        1:       v = (1 << (w - 1)) - 1;
        default: v = int'($urandom_range(0, (1 << w) - 1));
      endcase
      f = put_c(f, c, w, v);
    end
    return f;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic step();
    pend_t p;
    logic  exp_v;
    @(posedge clk);
    cyc++;
    if (en && n_rst) pq.push_back('{due: cyc + LAT, y4: x4_exp, y8: x8_exp});
    #1;
    exp_v = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      p     = pq.pop_front();
      exp_v = 1'b1;
      hold4 = p.y4;
      hold8 = p.y8;
    end
    chk("en_out_w4", eo4, exp_v);
    chk("en_out_w8", eo8, exp_v);
    chk("data_w4", out4, hold4);
    chk("data_w8", out8, hold8);
  endtask

  task automatic send(logic [127:0] f4, logic [255:0] f8, logic [127:0] e4, logic [255:0] e8);
    in4 = f4; in8 = f8; x4_exp = e4; x8_exp = e8; en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic send_rand();
    logic [255:0] r4, r8, e4;
    r4 = rand_frame(4);
    r8 = rand_frame(8);
    e4 = ref_fft(4, r4);
    send(r4[127:0], r8, e4[127:0], ref_fft(8, r8));
  endtask

  initial begin
    logic [255:0] f4, e4;
    int r0;
    checks = 0; errors = 0; cyc = 0;
    n_rst = 1'b0; en = 1'b0; in4 = '0; in8 = '0;
    x4_exp = '0; x8_exp = '0; hold4 = '0; hold8 = '0;

    for (int v = 0; v < 6; v++) vt[v] = '0;
    vt[0].w = 4; vt[1].w = 8; vt[2].w = 8; vt[3].w = 4; vt[4].w = 4; vt[5].w = 8;
    for (int k = 0; k < N; k++) begin
      vt[1].y = put_c(vt[1].y, 2 * k + 1, 8, 4);
      vt[2].x = put_c(vt[2].x, 2 * k + 1, 8, 16);
      vt[3].y = put_c(vt[3].y, 2 * k + 1, 4, -1);
      vt[4].x = put_c(vt[4].x, 2 * k + 1, 4, 7);
      vt[5].x = put_c(vt[5].x, 2 * k + 1, 8, -128);
    end
    vt[1].x = put_c(vt[1].x, 1, 8, 64);
    vt[2].y = put_c(vt[2].y, 1, 8, 16);
    vt[3].x = put_c(vt[3].x, 1, 4, -8);
    vt[4].y = put_c(vt[4].y, 1, 4, 7);
    vt[5].y = put_c(vt[5].y, 1, 8, -128);

    repeat (3) step();
    n_rst = 1'b1;
    repeat (2) step();

    for (int v = 0; v < 6; v++) begin
      if (vt[v].w == 4) send(vt[v].x[127:0], '0, vt[v].y[127:0], '0);
      else              send('0, vt[v].x, '0, vt[v].y);
      repeat (LAT + 1) step();
    end

    // repeating real pattern -8,-5,-3,-1
    f4 = '0;
    for (int k = 0; k < N; k++) begin
      case (k % 4)
        0:       f4 = put_c(f4, 2 * k + 1, 4, -8);
        1:       f4 = put_c(f4, 2 * k + 1, 4, -5);
        2:       f4 = put_c(f4, 2 * k + 1, 4, -3);
        default: f4 = put_c(f4, 2 * k + 1, 4, -1);
      endcase
    end
    e4 = ref_fft(4, f4);
    send(f4[127:0], '0, e4[127:0], '0);
    repeat (LAT) step();
    for (int k = 1; k < N; k++) begin
      if (k % 4 != 0) chk("pattern_bin_zero", out4[k*8 +: 8], '0);
    end
    r0 = get_c(out4, 1, 4);
    checks++;
    if (r0 != -5 && r0 != -4) begin
      errors++;
      $display("FAIL pattern_x0_real at cycle %0d: got %0d, expected -5 or -4", cyc, r0);
    end
    chk("pattern_x0_imag", out4[3:0], '0);
    step();

    for (int i = 0; i < 4; i++) send_rand();
    repeat (LAT + 2) step();

    send_rand();
    repeat (2) step();
    n_rst = 1'b0;
    #1;
    chk("reset_en_out_w4", eo4, '0);
    chk("reset_en_out_w8", eo8, '0);
    chk("reset_data_w4", out4, '0);
    chk("reset_data_w8", out8, '0);
    pq.delete();
    hold4 = '0; hold8 = '0;
    in4 = '1; in8 = '1; en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    n_rst = 1'b1;
    repeat (8) step();
    send_rand();
    repeat (LAT + 1) step();

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) != 0) send_rand();
      else step();
    end
    repeat (LAT + 2) step();
    chk("queue_drained", 256'(pq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
